// File: rtl/tridiag_det_loader_pkg.sv
// Shared state encoding and word-slot layout for the tridiagonal determinant loader.
package tridiag_pkg;

    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        ACK       = 3'd3,
        OUTPUT    = 3'd4
    } state_t;

    localparam int B_BASE = 0;

    function automatic int nwords(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int a_base(input int n);
        return n;
    endfunction

    function automatic int c_base(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int timeout_cycles(input int n);
        return 4 * n + 16;
    endfunction

endpackage

// File: rtl/tridiag_det_loader_if.sv
// Coefficient input stream and determinant result stream between host and loader.
interface tridiag_det_loader_if #(parameter int WIDTH = 16);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*WIDTH-1:0]     out_det;
    logic                   out_err;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_det, out_err);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_det, out_err);
endinterface

// File: rtl/tridiag_det_loader_coef_packer.sv
// Coefficient slot registers: word k lands in its b/a/c slot on a write strobe, one cycle latency.
// No backpressure of its own; contents persist until overwritten or reset.
module tridiag_coef_packer
    import tridiag_pkg::*;
#(
    parameter int N     = 16,
    parameter int WIDTH = 16,
    parameter int KW    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [KW-1:0]          k,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH*(N-1)-1:0] a_flat,
    output logic [WIDTH*N-1:0]     b_flat,
    output logic [WIDTH*(N-1)-1:0] c_flat
);
    localparam int A_BASE = a_base(N);
    localparam int C_BASE = c_base(N);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_flat <= '0;
            b_flat <= '0;
            c_flat <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N; i++) begin
                if (int'(k) == B_BASE + i) b_flat[i*WIDTH +: WIDTH] <= data;
            end
            for (int i = 0; i < N - 1; i++) begin
                if (int'(k) == A_BASE + i) a_flat[i*WIDTH +: WIDTH] <= data;
                if (int'(k) == C_BASE + i) c_flat[i*WIDTH +: WIDTH] <= data;
            end
        end
    end
endmodule

// File: rtl/tridiag_det_loader.sv
// Loads 3N-2 coefficient words, runs the core start/done/ack handshake, returns the determinant
// (start at t+1 after last beat; in_ready low from START to result handshake). TRIDIAG_DET_LOADER_TIMEOUT_EN adds a watchdog.
module tridiag_det_loader
    import tridiag_pkg::*;
#(
    parameter int N     = 16,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    tridiag_det_loader_if.slave    io,
    output logic                   core_start,
    output logic                   core_ack,
    input  logic                   core_done,
    input  logic [4*WIDTH-1:0]     core_det,
    output logic [WIDTH*(N-1)-1:0] a_flat,
    output logic [WIDTH*N-1:0]     b_flat,
    output logic [WIDTH*(N-1)-1:0] c_flat
);
    localparam int NW = nwords(N);
    localparam int KW = $clog2(NW + 1);

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q;
    logic [4*WIDTH-1:0] det_q;
    logic               accept, last_word, out_fire, timeout_exit;

    assign accept    = io.in_valid && io.in_ready;
    assign last_word = accept && (int'(k_q) == NW - 1);
    assign out_fire  = io.out_valid && io.out_ready;
    assign io.out_det = det_q;

`ifdef TRIDIAG_DET_LOADER_TIMEOUT_EN
    localparam int TO = timeout_cycles(N);
    localparam int TW = $clog2(TO + 1);

    logic [TW-1:0] wd_q;
    logic          err_q;

    // Counter value TO-1 marks the TO-th cycle spent waiting on the core.
    assign timeout_exit = (wd_q == TW'(TO - 1)) &&
                          ((state_q == WAIT_DONE && !core_done) ||
                           (state_q == ACK && core_done));
    assign io.out_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == START)
                wd_q <= '0;
            else if (state_q == WAIT_DONE || state_q == ACK)
                wd_q <= wd_q + 1'b1;

            if (state_q == WAIT_DONE && core_done)
                err_q <= 1'b0;
            else if (timeout_exit)
                err_q <= 1'b1;
            else if (out_fire)
                err_q <= 1'b0;
        end
    end
`else
    assign timeout_exit = 1'b0;
    assign io.out_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:      if (last_word) state_d = START;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: if (core_done) state_d = ACK;
                       else if (timeout_exit) state_d = OUTPUT;
            ACK:       if (!core_done || timeout_exit) state_d = OUTPUT;
            OUTPUT:    if (out_fire) state_d = LOAD;
            default:   state_d = LOAD;
        endcase
    end

    // Core strobes are masked by rst so they drop in the reset cycle itself.
    always_comb begin
        io.in_ready  = (state_q == LOAD);
        io.out_valid = (state_q == OUTPUT);
        core_start   = (state_q == START) && !rst;
        core_ack     = (state_q == ACK) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            det_q <= '0;
        end else begin
            if (accept)
                k_q <= k_q + 1'b1;
            else if (out_fire)
                k_q <= '0;

            if (state_q == WAIT_DONE && core_done)
                det_q <= core_det;
            else if (timeout_exit)
                det_q <= '0;
        end
    end

    tridiag_coef_packer #(.N(N), .WIDTH(WIDTH), .KW(KW)) u_packer (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (accept),
        .k      (k_q),
        .data   (io.in_data),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .c_flat (c_flat)
    );
endmodule
